// File: rtl/debug_dump_tx_if.sv
// Handshake bundle between the debug-dump serializer and its word source / UART TX FIFO.
// The slave modport is the serializer's view; master is the surrounding system.
interface debug_dump_tx_if #(
    parameter int SIZE      = 32,
    parameter int IDX_WIDTH = 6
);
    logic                 i_start;
    logic [IDX_WIDTH-1:0] o_word_idx;
    logic [SIZE-1:0]      i_word_data;
    logic                 i_tx_full;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic                 o_busy;
    logic                 o_done;

    modport slave (
        input  i_start,
        input  i_word_data,
        input  i_tx_full,
        output o_word_idx,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_word_data,
        output i_tx_full,
        input  o_word_idx,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/debug_dump_tx.sv
// Serializes NUM_WORDS debug words into a framed byte stream (A5, count, LE data, XOR checksum)
// pushed one byte per cycle into a UART TX FIFO, stalling whenever the FIFO reports full.
module debug_dump_tx #(
    parameter int SIZE      = 32,
    parameter int NUM_WORDS = 40,
    parameter int IDX_WIDTH = 6
) (
    input  logic                  clk_to_use,
    input  logic                  i_rst,
    debug_dump_tx_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        COUNT,
        LOAD,
        BYTE,
        CHECKSUM,
        DONE
    } state_t;

    localparam logic [7:0]           HDR_BYTE = 8'hA5;
    localparam logic [7:0]           CNT_BYTE = 8'(NUM_WORDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    state_t               state_q,    state_d;
    logic [IDX_WIDTH-1:0] idx_q,      idx_d;
    logic [SIZE-1:0]      shift_q,    shift_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [7:0]           csum_q,     csum_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q,  tx_data_d;

    // Reset clears every register, datapath included, so outputs read zero during reset.
    always_ff @(posedge clk_to_use or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = HEADER;
                end
            end

            HEADER: begin
                if (!bus.i_tx_full) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                    state_d    = COUNT;
                end
            end

            COUNT: begin
                if (!bus.i_tx_full) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CNT_BYTE;
                    csum_d     = CNT_BYTE;
                    state_d    = LOAD;
                end
            end

            // Word source is combinational on o_word_idx, so one capture cycle suffices.
            LOAD: begin
                shift_d    = bus.i_word_data;
                byte_cnt_d = 2'd0;
                state_d    = BYTE;
            end

            BYTE: begin
                if (!bus.i_tx_full) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shift_q[7:0];
                    csum_d     = csum_q ^ shift_q[7:0];
                    shift_d    = shift_q >> 8;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = CHECKSUM;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
            end

            CHECKSUM: begin
                if (!bus.i_tx_full) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = csum_q;
                    state_d    = DONE;
                end
            end

            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_word_idx = idx_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_done     = (state_q == DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: a 2-word and a default 40-word instance, each checked against a
// frame model built from the word table, under directed and random FIFO backpressure.
module tb_debug_dump_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_dump_tx_if #(.SIZE(32), .IDX_WIDTH(6)) bus_a ();
    debug_dump_tx_if #(.SIZE(32), .IDX_WIDTH(6)) bus_b ();

    debug_dump_tx #(.SIZE(32), .NUM_WORDS(2), .IDX_WIDTH(6)) dut_a (
        .clk_to_use (clk),
        .i_rst      (rst),
        .bus        (bus_a.slave)
    );

    debug_dump_tx dut_b (
        .clk_to_use (clk),
        .i_rst      (rst),
        .bus        (bus_b.slave)
    );

    logic [31:0] mem_a [2];
    logic [31:0] mem_b [40];

    always_comb bus_a.i_word_data = (int'(bus_a.o_word_idx) < 2)  ? mem_a[int'(bus_a.o_word_idx)] : 32'h0;
    always_comb bus_b.i_word_data = (int'(bus_b.o_word_idx) < 40) ? mem_b[int'(bus_b.o_word_idx)] : 32'h0;

    logic [7:0] got_a [$];
    logic [7:0] got_b [$];
    int done_a = 0, done_b = 0, busy_a = 0, busy_b = 0;
    event smp;

    // Observe on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus_a.o_tx_start) got_a.push_back(bus_a.o_tx_data);
        if (bus_b.o_tx_start) got_b.push_back(bus_b.o_tx_data);
        if (bus_a.o_done) done_a++;
        if (bus_b.o_done) done_b++;
        if (bus_a.o_busy) busy_a++;
        if (bus_b.o_busy) busy_b++;
        -> smp;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: header, count, little-endian words, XOR of everything but the header
    logic [7:0] exp_q [$];

    function automatic void build_exp(input int sel);
        int n;
        logic [7:0] cs;
        logic [31:0] w;
        n = (sel != 0) ? 40 : 2;
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        cs = 8'(n);
        for (int i = 0; i < n; i++) begin
            w = (sel != 0) ? mem_b[i] : mem_a[i];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(cs);
    endfunction

    function automatic int sz(input int sel);
        return (sel != 0) ? got_b.size() : got_a.size();
    endfunction

    function automatic logic [7:0] byte_at(input int sel, input int i);
        return (sel != 0) ? got_b[i] : got_a[i];
    endfunction

    function automatic int dcnt(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction

    function automatic int bcnt(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? bus_b.o_busy : bus_a.o_busy;
    endfunction

    task automatic drive(input int sel, input logic st, input logic fl);
        if (sel != 0) begin
            bus_b.i_start   = st;
            bus_b.i_tx_full = fl;
        end else begin
            bus_a.i_start   = st;
            bus_a.i_tx_full = fl;
        end
    endtask

    task automatic pulse_start(input int sel, input logic fl);
        @(smp);
        drive(sel, 1'b1, fl);
        @(smp);
        drive(sel, 1'b0, fl);
    endtask

    // Runs until the instance is idle; bp_pct is the per-cycle FIFO-full probability
    task automatic finish_frame(input int sel, input int bp_pct, input int restart_at, input string tag);
        int cyc;
        cyc = 0;
        while (busy_of(sel) && cyc < 3000) begin
            drive(sel, (cyc == restart_at), ($urandom_range(0, 99) < bp_pct));
            @(smp);
            cyc++;
        end
        drive(sel, 1'b0, 1'b0);
        chk({tag, "_timeout"}, (cyc < 3000), 1);
    endtask

    task automatic cmp_stream(input int sel, input int g0, input int d0, input string tag);
        int n;
        n = sz(sel) - g0;
        chk({tag, "_nstrobe"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), byte_at(sel, g0 + i), exp_q[i]);
        chk({tag, "_done"}, dcnt(sel) - d0, 1);
        chk({tag, "_idle"}, busy_of(sel), 0);
    endtask

    task automatic run_frame(input int sel, input int bp_pct, input int restart_at, input string tag);
        int g0, d0, b0, n;
        build_exp(sel);
        g0 = sz(sel);
        d0 = dcnt(sel);
        b0 = bcnt(sel);
        pulse_start(sel, 1'b0);
        finish_frame(sel, bp_pct, restart_at, tag);
        cmp_stream(sel, g0, d0, tag);
        // Without stalls: HEADER, COUNT, CHECKSUM, DONE plus LOAD and 4 bytes per word
        if (bp_pct == 0) begin
            n = (sel != 0) ? 40 : 2;
            chk({tag, "_busy_cycles"}, bcnt(sel) - b0, 4 + 5 * n);
        end
    endtask

    initial begin
        int g0, d0, cyc;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        foreach (mem_a[i]) mem_a[i] = 32'h0;
        foreach (mem_b[i]) mem_b[i] = 32'h0;

        // Reset state, with a start request held to show it is ignored under reset
        drive(0, 1'b1, 1'b0);
        repeat (3) @(smp);
        chk("rst_idx",   bus_a.o_word_idx, 0);
        chk("rst_start", bus_a.o_tx_start, 0);
        chk("rst_data",  bus_a.o_tx_data,  0);
        chk("rst_busy",  bus_a.o_busy,     0);
        chk("rst_done",  bus_a.o_done,     0);
        chk("rst_busy_b", bus_b.o_busy,    0);
        drive(0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(smp);

        // Reference two-word frame
        mem_a[0] = 32'h11223344;
        mem_a[1] = 32'hA0B0C0D0;
        run_frame(0, 0, -1, "basic");

        // Forty zero words
        run_frame(1, 0, -1, "zeros");
        chk("zeros_csum", got_b[got_b.size() - 1], 8'h28);

        // Three full cycles just before the second data byte
        build_exp(0);
        g0 = sz(0);
        d0 = dcnt(0);
        pulse_start(0, 1'b0);
        cyc = 0;
        while (sz(0) - g0 < 3 && cyc < 50) begin
            @(smp);
            cyc++;
        end
        chk("stall_reach", (cyc < 50), 1);
        drive(0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(smp);
            chk($sformatf("stall_nostrobe%0d", k), bus_a.o_tx_start, 0);
            chk($sformatf("stall_hold%0d", k), bus_a.o_tx_data, 8'h44);
        end
        drive(0, 1'b0, 1'b0);
        finish_frame(0, 0, -1, "stall");
        cmp_stream(0, g0, d0, "stall");

        // Start re-pulsed mid-frame
        run_frame(0, 0, 6, "restart");
        repeat (5) @(smp);
        chk("restart_stays_idle", busy_of(0), 0);

        // Reset after the fifth strobe, then a clean frame
        g0 = sz(0);
        pulse_start(0, 1'b0);
        cyc = 0;
        while (sz(0) - g0 < 5 && cyc < 50) begin
            @(smp);
            cyc++;
        end
        chk("midrst_reach", (cyc < 50), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",  bus_a.o_busy,     0);
        chk("midrst_start", bus_a.o_tx_start, 0);
        chk("midrst_data",  bus_a.o_tx_data,  0);
        chk("midrst_idx",   bus_a.o_word_idx, 0);
        chk("midrst_done",  bus_a.o_done,     0);
        g0 = sz(0);
        repeat (2) @(smp);
        rst = 1'b0;
        repeat (3) @(smp);
        chk("midrst_no_more", sz(0) - g0, 0);
        run_frame(0, 0, -1, "after_rst");

        // FIFO full at the header for ten cycles
        build_exp(0);
        g0 = sz(0);
        d0 = dcnt(0);
        pulse_start(0, 1'b1);
        repeat (10) @(smp);
        chk("hdrfull_nostrobe", sz(0) - g0, 0);
        chk("hdrfull_busy", bus_a.o_busy, 1);
        drive(0, 1'b0, 1'b0);
        finish_frame(0, 0, -1, "hdrfull");
        chk("hdrfull_first", (sz(0) > g0) ? byte_at(0, g0) : 8'h00, 8'hA5);
        cmp_stream(0, g0, d0, "hdrfull");

        // Random words under random backpressure
        for (int t = 0; t < 6; t++) begin
            foreach (mem_a[i]) mem_a[i] = $urandom;
            run_frame(0, 15 * t, (t == 3) ? 4 : -1, $sformatf("rnd_a%0d", t));
        end
        for (int t = 0; t < 2; t++) begin
            foreach (mem_b[i]) mem_b[i] = $urandom;
            run_frame(1, 20 + 20 * t, -1, $sformatf("rnd_b%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
